// File: rtl/traffic_pkg.sv
// Shared light encodings and phase type for the intersection scheduler.
package traffic_pkg;

  typedef logic [2:0] light_t;

  localparam light_t RED = 3'b001;
  localparam light_t YEL = 3'b010;
  localparam light_t GRE = 3'b100;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_t;

  // Lamp shown by the approach that currently owns the phase.
  function automatic light_t owner_lamp(input phase_t ph);
    case (ph)
      PH_GREEN:  owner_lamp = GRE;
      PH_YELLOW: owner_lamp = YEL;
      default:   owner_lamp = RED;
    endcase
  endfunction

endpackage

// File: rtl/rr_next_picker.sv
// Rotate-priority search: first set request strictly after cur_i, wrapping
// modulo N_APP (cur_i itself is considered last).
module rr_next_picker #(
  parameter int N_APP = 4,
  parameter int IDW   = $clog2(N_APP)
) (
  input  logic [N_APP-1:0] req_i,
  input  logic [IDW-1:0]   cur_i,
  output logic             found_o,
  output logic [IDW-1:0]   idx_o
);

  localparam int PW = IDW + 1;
  localparam logic [PW-1:0] NP = PW'(N_APP);

  logic [PW-1:0] pos;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = cur_i;
    pos     = '0;
    for (int k = N_APP; k >= 1; k--) begin
      pos = {1'b0, cur_i} + PW'(k);
      if (pos >= NP) begin
        pos = pos - NP;
      end
      if (req_i[pos[IDW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = pos[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/light_phase_scheduler.sv
// Round-robin green/yellow/all-red phase scheduler for N_APP approaches.
// Emergency preempt is built when LIGHT_PHASE_SCHEDULER_PREEMPT_EN is defined.
module light_phase_scheduler
  import traffic_pkg::*;
#(
  parameter  int N_APP      = 4,
  parameter  int MIN_GREEN  = 3,
  parameter  int MAX_GREEN  = 8,
  parameter  int YEL_CYC    = 2,
  parameter  int ALLRED_CYC = 1,
  localparam int IDW        = $clog2(N_APP)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_APP-1:0]   car_req,
  input  logic               preempt_req,
  input  logic [IDW-1:0]     preempt_id,
  output logic [3*N_APP-1:0] lights,
  output logic [IDW-1:0]     active_id,
  output logic [1:0]         phase,
  output logic               preempt_ack
);

  localparam int TW = $clog2(MAX_GREEN + 1);
  localparam logic [TW-1:0] T_MAX     = TW'(MAX_GREEN);
  localparam logic [TW-1:0] T_MIN_M1  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_MAX_M1  = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] T_YEL_END = TW'(YEL_CYC - 1);
  localparam logic [TW-1:0] T_AR_END  = TW'(ALLRED_CYC - 1);

  phase_t         phase_q, phase_d;
  logic [IDW-1:0] active_q, active_d;
  logic [IDW-1:0] next_q, next_d;
  logic [TW-1:0]  timer_q, timer_d;

  logic [N_APP-1:0] active_mask;
  logic [N_APP-1:0] other_req;
  logic             own_req;
  logic             pick_found;
  logic [IDW-1:0]   pick_idx;

  logic pre_go;    // preempt towards another approach: leave green now
  logic pre_hold;  // preempted approach already green: freeze
  logic pre_load;  // preempt present: steer the pending handover

  assign active_mask = N_APP'(1) << active_q;
  assign other_req   = car_req & ~active_mask;
  assign own_req     = car_req[active_q];

  rr_next_picker #(
    .N_APP (N_APP),
    .IDW   (IDW)
  ) u_picker (
    .req_i   (other_req),
    .cur_i   (active_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

`ifdef LIGHT_PHASE_SCHEDULER_PREEMPT_EN
  assign pre_hold    = preempt_req && (preempt_id == active_q);
  assign pre_go      = preempt_req && (preempt_id != active_q);
  assign pre_load    = preempt_req;
  assign preempt_ack = (phase_q == PH_GREEN) && pre_hold;
`else
  logic unused_preempt;
  assign unused_preempt = ^{preempt_req, preempt_id};
  assign pre_hold    = 1'b0;
  assign pre_go      = 1'b0;
  assign pre_load    = 1'b0;
  assign preempt_ack = 1'b0;
`endif

  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    next_d   = next_q;
    case (phase_q)
      PH_GREEN: begin
        if (pre_go) begin
          phase_d = PH_YELLOW;
          next_d  = preempt_id;
        end else if (!pre_hold && pick_found && (timer_q >= T_MIN_M1) &&
                     (!own_req || (timer_q >= T_MAX_M1))) begin
          phase_d = PH_YELLOW;
          next_d  = pick_idx;
        end
      end
      PH_YELLOW: begin
        if (pre_load) begin
          next_d = preempt_id;
        end
        if (timer_q == T_YEL_END) begin
          phase_d = PH_ALLRED;
        end
      end
      PH_ALLRED: begin
        if (pre_load) begin
          next_d = preempt_id;
        end
        if (timer_q == T_AR_END) begin
          phase_d  = PH_GREEN;
          active_d = next_q;
        end
      end
      default: begin
        phase_d = PH_GREEN;
      end
    endcase

    // Timer restarts on every phase change and saturates while resting.
    if (phase_d != phase_q) begin
      timer_d = '0;
    end else if (timer_q == T_MAX) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_GREEN;
      active_q <= '0;
      next_q   <= '0;
      timer_q  <= '0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      next_q   <= next_d;
      timer_q  <= timer_d;
    end
  end

  for (genvar gi = 0; gi < N_APP; gi++) begin : g_lamp
    assign lights[3*gi +: 3] = (active_q == IDW'(gi)) ? owner_lamp(phase_q) : RED;
  end

  assign active_id = active_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_light_phase_scheduler.sv
// Directed bench for light_phase_scheduler with default parameters (4 approaches).
module tb_light_phase_scheduler;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  car_req;
  logic          preempt_req;
  logic [1:0]    preempt_id;
  logic [3*N-1:0] lights;
  logic [1:0]    active_id;
  logic [1:0]    phase;
  logic          preempt_ack;

  int vectors;
  int miscompares;

  light_phase_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .car_req     (car_req),
    .preempt_req (preempt_req),
    .preempt_id  (preempt_id),
    .lights      (lights),
    .active_id   (active_id),
    .phase       (phase),
    .preempt_ack (preempt_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected light word: owner shows GRE/YEL in green/yellow, everything else RED.
  function automatic logic [3*N-1:0] exp_lights(input int ph, input int id);
    logic [3*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (i == id && ph == 0)      v[3*i +: 3] = 3'b100;
      else if (i == id && ph == 1) v[3*i +: 3] = 3'b010;
      else                         v[3*i +: 3] = 3'b001;
    end
    return v;
  endfunction

  // Leaves the bench on a falling edge with the post-reset state (cycle 0) visible.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    car_req = '0; preempt_req = 1'b0; preempt_id = '0;
    do_reset();
    vectors++;
    if (lights !== exp_lights(0, 0)) begin
      miscompares++;
      $display("FAIL reset_lights: got %b want %b", lights, exp_lights(0, 0));
    end
    vectors++;
    if (phase !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_phase: got %0d want 0", phase);
    end
    vectors++;
    if (active_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_active: got %0d want 0", active_id);
    end
    vectors++;
    if (preempt_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ack: got %b want 0", preempt_ack);
    end
    $display("test_reset done: lights=%b phase=%0d id=%0d", lights, phase, active_id);
  endtask

  task automatic test_rest_in_place();
    car_req = '0;
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) step();
      vectors++;
      if (lights !== exp_lights(0, 0) || phase !== 2'd0 || active_id !== 2'd0) begin
        miscompares++;
        $display("FAIL rest cycle %0d: lights=%b phase=%0d id=%0d want lights=%b phase=0 id=0",
                 k, lights, phase, active_id, exp_lights(0, 0));
      end
    end
    // Timer long past MIN_GREEN: a new request leaves green on the next edge.
    car_req = 4'b0010;
    step();
    vectors++;
    if (lights !== exp_lights(1, 0) || phase !== 2'd1) begin
      miscompares++;
      $display("FAIL rest_release: lights=%b phase=%0d want lights=%b phase=1",
               lights, phase, exp_lights(1, 0));
    end
    $display("test_rest_in_place done");
  endtask

  task automatic test_gap_out();
    int ph_t[8] = '{0, 0, 0, 1, 1, 2, 0, 0};
    int id_t[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    car_req = '0;
    do_reset();
    car_req = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      vectors++;
      if (lights !== exp_lights(ph_t[k], id_t[k]) || phase !== 2'(ph_t[k]) ||
          active_id !== 2'(id_t[k])) begin
        miscompares++;
        $display("FAIL gap_out cycle %0d: lights=%b phase=%0d id=%0d want lights=%b phase=%0d id=%0d",
                 k, lights, phase, active_id, exp_lights(ph_t[k], id_t[k]), ph_t[k], id_t[k]);
      end
    end
    $display("test_gap_out done");
  endtask

  task automatic test_round_robin();
    int seg, off, ph, id;
    car_req = '0;
    do_reset();
    car_req = 4'b1111;
    // Each handover spans 8 green + 2 yellow + 1 all-red = 11 cycles.
    for (int k = 0; k <= 52; k++) begin
      if (k > 0) step();
      seg = k / 11;
      off = k % 11;
      id  = seg % 4;
      ph  = (off < 8) ? 0 : ((off < 10) ? 1 : 2);
      vectors++;
      if (lights !== exp_lights(ph, id) || phase !== 2'(ph) || active_id !== 2'(id)) begin
        miscompares++;
        $display("FAIL round_robin cycle %0d: lights=%b phase=%0d id=%0d want lights=%b phase=%0d id=%0d",
                 k, lights, phase, active_id, exp_lights(ph, id), ph, id);
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_wrap_order();
    int ph_t[19] = '{0,0,0,1,1,2, 0,0,0,1,1,2, 0,0,0,1,1,2, 0};
    int id_t[19] = '{0,0,0,0,0,0, 2,2,2,2,2,2, 3,3,3,3,3,3, 0};
    car_req = '0;
    do_reset();
    car_req = 4'b0100;
    for (int k = 0; k < 19; k++) begin
      if (k > 0) step();
      vectors++;
      if (lights !== exp_lights(ph_t[k], id_t[k]) || phase !== 2'(ph_t[k]) ||
          active_id !== 2'(id_t[k])) begin
        miscompares++;
        $display("FAIL wrap cycle %0d: lights=%b phase=%0d id=%0d want lights=%b phase=%0d id=%0d",
                 k, lights, phase, active_id, exp_lights(ph_t[k], id_t[k]), ph_t[k], id_t[k]);
      end
      if (k == 6) car_req = 4'b1011;
      if (k == 9) car_req = 4'b0011;
    end
    $display("test_wrap_order done");
  endtask

  task automatic test_reset_mid_yellow();
    car_req = '0;
    do_reset();
    car_req = 4'b0010;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 6) car_req = 4'b0001;
    end
    vectors++;
    if (phase !== 2'd1 || active_id !== 2'd1 || lights !== exp_lights(1, 1)) begin
      miscompares++;
      $display("FAIL pre_reset_yellow: lights=%b phase=%0d id=%0d want lights=%b phase=1 id=1",
               lights, phase, active_id, exp_lights(1, 1));
    end
    rst = 1'b1;
    car_req = 4'b0010;
    step();
    rst = 1'b0;
    // A cleared timer means exactly MIN_GREEN green cycles before yellow.
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) step();
      vectors++;
      if (lights !== exp_lights((k == 3) ? 1 : 0, 0) || active_id !== 2'd0 ||
          phase !== ((k == 3) ? 2'd1 : 2'd0)) begin
        miscompares++;
        $display("FAIL mid_yellow_reset cycle %0d: lights=%b phase=%0d id=%0d want lights=%b id=0",
                 k, lights, phase, active_id, exp_lights((k == 3) ? 1 : 0, 0));
      end
    end
    $display("test_reset_mid_yellow done");
  endtask

`ifdef LIGHT_PHASE_SCHEDULER_PREEMPT_EN
  task automatic test_preempt();
    int ph, id;
    logic ack_w;
    car_req = '0; preempt_req = 1'b0;
    do_reset();
    car_req = 4'b0011; preempt_req = 1'b1; preempt_id = 2'd2;
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) step();
      ph    = (k == 0 || k >= 4) ? 0 : ((k < 3) ? 1 : 2);
      id    = (k >= 4) ? 2 : 0;
      ack_w = (k >= 4);
      vectors++;
      if (lights !== exp_lights(ph, id) || phase !== 2'(ph) || preempt_ack !== ack_w) begin
        miscompares++;
        $display("FAIL preempt cycle %0d: lights=%b phase=%0d ack=%b want lights=%b phase=%0d ack=%b",
                 k, lights, phase, preempt_ack, exp_lights(ph, id), ph, ack_w);
      end
    end
    preempt_req = 1'b0;
    step();
    vectors++;
    if (lights !== exp_lights(1, 2) || preempt_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL preempt_release: lights=%b ack=%b want lights=%b ack=0",
               lights, preempt_ack, exp_lights(1, 2));
    end
    $display("test_preempt done");
  endtask
`else
  task automatic test_preempt();
    car_req = '0; preempt_req = 1'b0;
    do_reset();
    preempt_req = 1'b1; preempt_id = 2'd2;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      vectors++;
      if (lights !== exp_lights(0, 0) || phase !== 2'd0 || preempt_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL preempt_ignored cycle %0d: lights=%b phase=%0d ack=%b want lights=%b phase=0 ack=0",
                 k, lights, phase, preempt_ack, exp_lights(0, 0));
      end
    end
    preempt_req = 1'b0;
    $display("test_preempt done");
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    car_req = '0;
    preempt_req = 1'b0;
    preempt_id = '0;
    test_reset();
    test_rest_in_place();
    test_gap_out();
    test_round_robin();
    test_wrap_order();
    test_reset_mid_yellow();
    test_preempt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
